// File: rtl/phy16_pkg.sv
// Shared definitions for the 16-bit 8b10b PHY receive path: legal K
// characters, the word-sync state encoding and a K-character check.
package phy16_pkg;

    localparam logic [7:0] c_K28_5 = 8'hBC;
    localparam logic [7:0] c_K23_7 = 8'hF7;
    localparam logic [7:0] c_K27_7 = 8'hFB;
    localparam logic [7:0] c_K29_7 = 8'hFD;
    localparam logic [7:0] c_K30_7 = 8'hFE;

    typedef enum logic [1:0] {
        ST_LOSS    = 2'd0,
        ST_ACQ     = 2'd1,
        ST_SYNC_OK = 2'd2
    } t_sync_state;

    // True when a byte flagged K is one of the control characters the link uses.
    function automatic logic f_is_legal_k(input logic [7:0] i_byte);
        logic v_ok;
        case (i_byte)
            c_K28_5, c_K23_7, c_K27_7, c_K29_7, c_K30_7: v_ok = 1'b1;
            default:                                     v_ok = 1'b0;
        endcase
        return v_ok;
    endfunction

endpackage

// File: rtl/phy16_word_classifier.sv
// Purely combinational per-word classification of a decoded 16-bit symbol
// word: legal, comma (K28.5 in the comma lane) and bad.
module phy16_word_classifier
    import phy16_pkg::*;
#(
    parameter int g_comma_lane = 0
) (
    input  logic [15:0] i_data,
    input  logic [1:0]  i_k,
    input  logic        i_enc_err,
    output logic        o_legal,
    output logic        o_comma,
    output logic        o_bad
);

    logic [1:0] w_lane_ok;

    // A lane is fine when it is data, or a known K character; K28.5 is only
    // accepted in the comma lane so a byte-slipped stream is caught.
    for (genvar n = 0; n < 2; n++) begin : g_lane
        assign w_lane_ok[n] = ~i_k[n]
                            | (f_is_legal_k(i_data[8*n +: 8])
                               & ((i_data[8*n +: 8] != c_K28_5) || (n == g_comma_lane)));
    end

    assign o_legal = ~i_enc_err & (&w_lane_ok);
    assign o_comma = o_legal & i_k[g_comma_lane]
                   & (i_data[8*g_comma_lane +: 8] == c_K28_5);
    assign o_bad   = ~o_legal;

endmodule

// File: rtl/phy16_rx_sync_monitor.sv
// Receive-side word-sync monitor: acquires lock on consecutive commas, drops
// it after repeated bad words (with healing on runs of good words), counts
// errors and losses, and forwards registered data only while synchronised.
// Note: rst_n_i is active-high despite its name (legacy codebase reset).
module phy16_rx_sync_monitor
    import phy16_pkg::*;
#(
    parameter int g_comma_lane   = 0,
    parameter int g_acq_commas   = 3,
    parameter int g_max_bad      = 4,
    parameter int g_good_to_heal = 4
) (
    input  logic        clk_sys_i,
    input  logic        rst_n_i,
    input  logic        rx_valid_i,
    input  logic [15:0] rx_data_i,
    input  logic [1:0]  rx_k_i,
    input  logic        rx_enc_err_i,
    input  logic        clr_cnt_i,
    output logic        rx_valid_o,
    output logic [15:0] rx_data_o,
    output logic [1:0]  rx_k_o,
    output logic        sync_o,
    output logic        sync_lost_p1_o,
    output logic [15:0] err_cnt_o,
    output logic [7:0]  sync_loss_cnt_o
);

    localparam logic [2:0] lc_acq_commas = 3'(g_acq_commas);
    localparam logic [2:0] lc_max_bad    = 3'(g_max_bad);
    localparam logic [2:0] lc_heal       = 3'(g_good_to_heal);

    logic        w_legal, w_comma, w_bad;
    t_sync_state r_state, w_state_nxt;
    logic [2:0]  r_acq_cnt, w_acq_nxt;
    logic [2:0]  r_strikes, w_strikes_nxt;
    logic [2:0]  r_good_cnt, w_good_nxt;
    logic        w_lost;
    logic [2:0]  w_acq_inc, w_strikes_inc, w_good_inc;
    logic        r_rx_valid, r_sync, r_lost_p1;
    logic [15:0] r_rx_data, r_err_cnt;
    logic [1:0]  r_rx_k;
    logic [7:0]  r_loss_cnt;

    phy16_word_classifier #(
        .g_comma_lane (g_comma_lane)
    ) u_classifier (
        .i_data    (rx_data_i),
        .i_k       (rx_k_i),
        .i_enc_err (rx_enc_err_i),
        .o_legal   (w_legal),
        .o_comma   (w_comma),
        .o_bad     (w_bad)
    );

    assign w_acq_inc     = r_acq_cnt + 3'd1;
    assign w_strikes_inc = r_strikes + 3'd1;
    assign w_good_inc    = r_good_cnt + 3'd1;

    // Next-state logic for the word-sync FSM and its acquire/strike/heal counters.
    always_comb begin
        w_state_nxt   = r_state;
        w_acq_nxt     = r_acq_cnt;
        w_strikes_nxt = r_strikes;
        w_good_nxt    = r_good_cnt;
        w_lost        = 1'b0;
        case (r_state)
            ST_LOSS: begin
                if (rx_valid_i && w_comma) begin
                    if (lc_acq_commas == 3'd1) begin
                        w_state_nxt = ST_SYNC_OK;
                        w_acq_nxt   = 3'd0;
                    end else begin
                        w_state_nxt = ST_ACQ;
                        w_acq_nxt   = 3'd1;
                    end
                end else begin
                    w_acq_nxt = 3'd0;
                end
            end
            ST_ACQ: begin
                if (rx_valid_i && w_comma) begin
                    if (w_acq_inc >= lc_acq_commas) begin
                        w_state_nxt   = ST_SYNC_OK;
                        w_acq_nxt     = 3'd0;
                        w_strikes_nxt = 3'd0;
                        w_good_nxt    = 3'd0;
                    end else begin
                        w_acq_nxt = w_acq_inc;
                    end
                end else if (rx_valid_i && w_bad) begin
                    w_state_nxt = ST_LOSS;
                    w_acq_nxt   = 3'd0;
                end else begin
                    w_acq_nxt = r_acq_cnt;
                end
            end
            ST_SYNC_OK: begin
                if (rx_valid_i && w_bad) begin
                    w_good_nxt = 3'd0;
                    if (w_strikes_inc >= lc_max_bad) begin
                        w_state_nxt   = ST_LOSS;
                        w_strikes_nxt = 3'd0;
                        w_lost        = 1'b1;
                    end else begin
                        w_strikes_nxt = w_strikes_inc;
                    end
                end else if (rx_valid_i) begin
                    if (r_strikes == 3'd0) begin
                        w_good_nxt = 3'd0;
                    end else if (w_good_inc >= lc_heal) begin
                        w_strikes_nxt = r_strikes - 3'd1;
                        w_good_nxt    = 3'd0;
                    end else begin
                        w_good_nxt = w_good_inc;
                    end
                end else begin
                    w_good_nxt = r_good_cnt;
                end
            end
            default: begin
                w_state_nxt   = ST_LOSS;
                w_acq_nxt     = 3'd0;
                w_strikes_nxt = 3'd0;
                w_good_nxt    = 3'd0;
            end
        endcase
    end

    // FSM state and counter registers.
    always_ff @(posedge clk_sys_i or posedge rst_n_i) begin
        if (rst_n_i) begin
            r_state    <= ST_LOSS;
            r_acq_cnt  <= 3'd0;
            r_strikes  <= 3'd0;
            r_good_cnt <= 3'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_acq_cnt  <= w_acq_nxt;
            r_strikes  <= w_strikes_nxt;
            r_good_cnt <= w_good_nxt;
        end
    end

    // Registered data path and status outputs; qualification uses the pre-update state.
    always_ff @(posedge clk_sys_i or posedge rst_n_i) begin
        if (rst_n_i) begin
            r_rx_valid <= 1'b0;
            r_rx_data  <= 16'h0000;
            r_rx_k     <= 2'b00;
            r_sync     <= 1'b0;
            r_lost_p1  <= 1'b0;
        end else begin
            r_rx_valid <= rx_valid_i & w_legal & (r_state == ST_SYNC_OK);
            r_sync     <= (w_state_nxt == ST_SYNC_OK);
            r_lost_p1  <= w_lost;
            if (rx_valid_i) begin
                r_rx_data <= rx_data_i;
                r_rx_k    <= rx_k_i;
            end
        end
    end

    // Saturating error and sync-loss counters; clear wins over a same-cycle increment.
    always_ff @(posedge clk_sys_i or posedge rst_n_i) begin
        if (rst_n_i) begin
            r_err_cnt  <= 16'h0000;
            r_loss_cnt <= 8'h00;
        end else if (clr_cnt_i) begin
            r_err_cnt  <= 16'h0000;
            r_loss_cnt <= 8'h00;
        end else begin
            if (rx_valid_i && w_bad && (r_err_cnt != 16'hFFFF)) begin
                r_err_cnt <= r_err_cnt + 16'h0001;
            end
            if (w_lost && (r_loss_cnt != 8'hFF)) begin
                r_loss_cnt <= r_loss_cnt + 8'h01;
            end
        end
    end

    assign rx_valid_o      = r_rx_valid;
    assign rx_data_o       = r_rx_data;
    assign rx_k_o          = r_rx_k;
    assign sync_o          = r_sync;
    assign sync_lost_p1_o  = r_lost_p1;
    assign err_cnt_o       = r_err_cnt;
    assign sync_loss_cnt_o = r_loss_cnt;

endmodule
